// File: rtl/mmio_wq_pkg.sv
// Shared constants and helpers for the MMIO write queue: default window base,
// channel indices and the pointer-width function.
package mmio_wq_pkg;

    localparam logic [13:0] MMIO_WQ_BASE_ADDR = 14'h3F00;

    localparam int CH_PRAM  = 0;
    localparam int CH_LCD   = 1;
    localparam int CH_SPARE = 2;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_wq_fifo.sv
// Single-channel show-ahead FIFO used by mmio_write_queue. Pointers carry one
// extra wrap bit so full and empty can be told apart without a counter.
module mmio_wq_fifo
    import mmio_wq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: an entry is only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_write_queue.sv
// Routes CPU writes in a NUM_CH-word window into per-channel FIFOs, stalling the
// CPU on a full channel. Define MMIO_WQ_DROP_EN to drop such writes and flag them instead.
module mmio_write_queue
    import mmio_wq_pkg::*;
#(
    parameter int                NUM_CH    = 3,
    parameter int                DEPTH     = 8,
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(MMIO_WQ_BASE_ADDR)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_data,
    output logic                     cpu_hit,
    output logic                     cpu_stall,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        ch_full,
    output logic [NUM_CH-1:0]        ch_overflow
);

    logic [ADDR_W-1:0] sel;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              write_blocked;

    assign sel     = cpu_addr - BASE_ADDR;
    assign cpu_hit = (cpu_addr >= BASE_ADDR) && (sel < ADDR_W'(NUM_CH));

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = cpu_hit && (sel == ADDR_W'(i));
        end
    end

    // Handshake: a channel entry moves to its consumer on a clk edge where
    // ch_valid && ch_ready; ch_data is stable while ch_valid is high and not popped.
    assign write_blocked = cpu_we && |(ch_sel & ch_full);
    assign push          = {NUM_CH{cpu_we}} & ch_sel & ~ch_full;
    assign pop           = ch_ready & ch_valid;

`ifdef MMIO_WQ_DROP_EN
    assign cpu_stall = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_overflow <= '0;
        end else if (write_blocked) begin
            ch_overflow <= ch_overflow | (ch_sel & ch_full);
        end
    end
`else
    // Full state comes from registers only, so the stall never sees ch_ready.
    assign cpu_stall   = write_blocked;
    assign ch_overflow = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mmio_wq_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[g]),
            .push_data (cpu_data),
            .pop       (pop[g]),
            .head      (ch_data[g*DATA_W +: DATA_W]),
            .valid     (ch_valid[g]),
            .full      (ch_full[g])
        );
    end

endmodule

// File: tb/tb_mmio_write_queue.sv
// Randomised bench for mmio_write_queue against a queue-based reference model.
// Honours MMIO_WQ_DROP_EN the same way as the design.
module tb_mmio_write_queue;
    import mmio_wq_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam logic [ADDR_W-1:0] BASE = MMIO_WQ_BASE_ADDR;

    logic                     clk;
    logic                     reset;
    logic                     cpu_we;
    logic [ADDR_W-1:0]        cpu_addr;
    logic [DATA_W-1:0]        cpu_data;
    logic                     cpu_hit;
    logic                     cpu_stall;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        ch_full;
    logic [NUM_CH-1:0]        ch_overflow;

    mmio_write_queue #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_hit(cpu_hit), .cpu_stall(cpu_stall), .ch_data(ch_data), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .ch_full(ch_full), .ch_overflow(ch_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue of pending words per channel.
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    logic [NUM_CH-1:0] exp_ovf;

    // Pre-edge DUT samples and model expectations for the same instant.
    logic                     stall_seen, hit_seen;
    logic [NUM_CH-1:0]        valid_seen, full_seen;
    logic [NUM_CH*DATA_W-1:0] head_seen;
    logic                     exp_stall, exp_hit, last_accept;
    logic [NUM_CH-1:0]        exp_valid, exp_full;
    logic [NUM_CH*DATA_W-1:0] exp_head;

    // One clock cycle: drive, sample mid-cycle, advance model across the edge.
    task automatic drive_cycle(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic [NUM_CH-1:0] ready);
        int sel;
        logic accept, blocked;
        logic [NUM_CH-1:0] pop_mask;
        cpu_we = we; cpu_addr = addr; cpu_data = data; ch_ready = ready;
        #2;
        stall_seen = cpu_stall; hit_seen = cpu_hit; valid_seen = ch_valid;
        full_seen = ch_full; head_seen = ch_data;
        sel = int'(addr) - int'(BASE);
        exp_hit = (sel >= 0) && (sel < NUM_CH);
        exp_head = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            exp_valid[i] = (exp_q[i].size() != 0);
            exp_full[i]  = (exp_q[i].size() == DEPTH);
            if (exp_valid[i]) exp_head[i*DATA_W +: DATA_W] = exp_q[i][0];
            pop_mask[i] = ready[i] && exp_valid[i];
        end
        accept = 1'b0; blocked = 1'b0;
        if (we && exp_hit) begin
            if (exp_q[sel].size() == DEPTH) blocked = 1'b1;
            else accept = 1'b1;
        end
`ifdef MMIO_WQ_DROP_EN
        exp_stall = 1'b0;
`else
        exp_stall = blocked;
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop_mask[i]) void'(exp_q[i].pop_front());
        end
        if (accept) exp_q[sel].push_back(data);
`ifdef MMIO_WQ_DROP_EN
        if (blocked) exp_ovf[sel] = 1'b1;
`endif
        last_accept = accept;
    endtask

    task automatic apply_reset();
        reset = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0; ch_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
        exp_ovf = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_we = 1'b1; cpu_addr = BASE; cpu_data = '0; ch_ready = '0;
        #3;
        total++; if (ch_valid !== '0) begin bad++; $display("FAIL reset_valid got=%b exp=%b", ch_valid, 3'b000); end
        total++; if (ch_full !== '0) begin bad++; $display("FAIL reset_full got=%b exp=%b", ch_full, 3'b000); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
        total++; if (ch_overflow !== '0) begin bad++; $display("FAIL reset_overflow got=%b exp=%b", ch_overflow, 3'b000); end
        apply_reset();
    endtask

    task automatic test_single_write();
        drive_cycle(1'b1, BASE + ADDR_W'(CH_LCD), 16'hA5A5, 3'b000);
        total++; if (stall_seen !== 1'b0) begin bad++; $display("FAIL single_stall got=%b exp=0", stall_seen); end
        total++; if (ch_valid !== 3'b010) begin bad++; $display("FAIL single_valid got=%b exp=010", ch_valid); end
        total++; if (ch_data[31:16] !== 16'hA5A5) begin bad++; $display("FAIL single_data got=%h exp=a5a5", ch_data[31:16]); end
        drive_cycle(1'b0, '0, '0, 3'b010);
        total++; if (ch_valid !== 3'b000) begin bad++; $display("FAIL single_pop got=%b exp=000", ch_valid); end
    endtask

    task automatic test_out_of_window();
        logic [ADDR_W-1:0] addrs [5];
        addrs[0] = 14'h3EFF; addrs[1] = 14'h3F03; addrs[2] = 14'h3F00;
        addrs[3] = 14'h3F02; addrs[4] = ADDR_W'($urandom_range(0, 16'h3EFF));
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, addrs[k], DATA_W'($urandom), 3'b000);
            total++; if (hit_seen !== exp_hit) begin bad++; $display("FAIL window_hit addr=%h got=%b exp=%b", addrs[k], hit_seen, exp_hit); end
            total++; if (stall_seen !== 1'b0) begin bad++; $display("FAIL window_stall addr=%h got=%b exp=0", addrs[k], stall_seen); end
            for (int i = 0; i < NUM_CH; i++) exp_valid[i] = (exp_q[i].size() != 0);
            total++; if (ch_valid !== exp_valid) begin bad++; $display("FAIL window_valid addr=%h got=%b exp=%b", addrs[k], ch_valid, exp_valid); end
        end
        repeat (2) drive_cycle(1'b0, '0, '0, 3'b111);
    endtask

`ifndef MMIO_WQ_DROP_EN
    task automatic test_stall_build();
        logic [DATA_W-1:0] got [$];
        for (int v = 1; v <= 8; v++) drive_cycle(1'b1, BASE + ADDR_W'(CH_PRAM), DATA_W'(v), 3'b000);
        total++; if (ch_full !== 3'b001) begin bad++; $display("FAIL build_full got=%b exp=001", ch_full); end
        drive_cycle(1'b1, BASE, 16'd9, 3'b000);
        total++; if (stall_seen !== 1'b1) begin bad++; $display("FAIL build_stall9 got=%b exp=1", stall_seen); end
        drive_cycle(1'b1, BASE, 16'd9, 3'b001);
        total++; if (stall_seen !== 1'b1) begin bad++; $display("FAIL build_stall_pop got=%b exp=1", stall_seen); end
        if (valid_seen[0]) got.push_back(head_seen[15:0]);
        drive_cycle(1'b1, BASE, 16'd9, 3'b000);
        total++; if (stall_seen !== 1'b0) begin bad++; $display("FAIL build_accept got=%b exp=0", stall_seen); end
        total++; if (ch_full[0] !== 1'b1) begin bad++; $display("FAIL build_refull got=%b exp=1", ch_full[0]); end
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, '0, '0, 3'b001);
            if (valid_seen[0]) got.push_back(head_seen[15:0]);
        end
        total++; if (got.size() !== 9) begin bad++; $display("FAIL build_count got=%0d exp=9", got.size()); end
        for (int k = 0; k < got.size() && k < 9; k++) begin
            total++; if (got[k] !== DATA_W'(k + 1)) begin bad++; $display("FAIL build_order idx=%0d got=%0d exp=%0d", k, got[k], k + 1); end
        end
    endtask

    task automatic test_full_pop_push();
        for (int v = 0; v < DEPTH; v++) drive_cycle(1'b1, BASE + ADDR_W'(CH_SPARE), DATA_W'($urandom), 3'b000);
        drive_cycle(1'b1, BASE + ADDR_W'(CH_SPARE), 16'h0042, 3'b100);
        total++; if (stall_seen !== 1'b1) begin bad++; $display("FAIL fpp_stall got=%b exp=1", stall_seen); end
        total++; if (ch_full[2] !== 1'b0) begin bad++; $display("FAIL fpp_after_pop got=%b exp=0", ch_full[2]); end
        drive_cycle(1'b1, BASE + ADDR_W'(CH_SPARE), 16'h0042, 3'b000);
        total++; if (stall_seen !== 1'b0) begin bad++; $display("FAIL fpp_accept got=%b exp=0", stall_seen); end
        total++; if (ch_full[2] !== 1'b1) begin bad++; $display("FAIL fpp_refull got=%b exp=1", ch_full[2]); end
        for (int c = 0; c < 12; c++) begin
            drive_cycle(1'b0, '0, '0, 3'b100);
            if (exp_valid[2]) begin
                total++; if (head_seen[47:32] !== exp_head[47:32]) begin bad++; $display("FAIL fpp_data cyc=%0d got=%h exp=%h", c, head_seen[47:32], exp_head[47:32]); end
            end
        end
        total++; if (ch_valid[2] !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b exp=0", ch_valid[2]); end
    endtask
`else
    task automatic test_drop();
        logic [DATA_W-1:0] got [$];
        for (int v = 1; v <= 8; v++) drive_cycle(1'b1, BASE, DATA_W'(v), 3'b000);
        drive_cycle(1'b1, BASE, 16'd9, 3'b000);
        total++; if (stall_seen !== 1'b0) begin bad++; $display("FAIL drop_stall got=%b exp=0", stall_seen); end
        total++; if (ch_overflow !== 3'b001) begin bad++; $display("FAIL drop_flag got=%b exp=001", ch_overflow); end
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, '0, '0, 3'b001);
            if (valid_seen[0]) got.push_back(head_seen[15:0]);
        end
        total++; if (got.size() !== 8) begin bad++; $display("FAIL drop_count got=%0d exp=8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            total++; if (got[k] !== DATA_W'(k + 1)) begin bad++; $display("FAIL drop_order idx=%0d got=%0d exp=%0d", k, got[k], k + 1); end
        end
        total++; if (ch_overflow !== 3'b001) begin bad++; $display("FAIL drop_sticky got=%b exp=001", ch_overflow); end
        apply_reset();
        total++; if (ch_overflow !== 3'b000) begin bad++; $display("FAIL drop_clear got=%b exp=000", ch_overflow); end
    endtask
`endif

    task automatic test_random();
        int push_cnt [2];
        int cyc;
        int req_ch;
        logic hold;
        logic req_we;
        logic [ADDR_W-1:0] req_addr;
        logic [DATA_W-1:0] req_data;
        logic [NUM_CH-1:0] rdy;
        push_cnt[0] = 0; push_cnt[1] = 0; cyc = 0; hold = 1'b0;
        req_we = 1'b0; req_addr = '0; req_data = '0; req_ch = 0;
        while ((push_cnt[0] < 3 * DEPTH || push_cnt[1] < 3 * DEPTH) && cyc < 2000) begin
            if (!hold) begin
                req_we = ($urandom_range(0, 4) != 0);
                req_data = DATA_W'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    req_ch = -1;
                    req_addr = ($urandom_range(0, 1) == 0) ? 14'h3EFF : 14'h3F05;
                end else begin
                    req_ch = $urandom_range(0, 1);
                    req_addr = BASE + ADDR_W'(req_ch);
                end
            end
            rdy = '0;
            rdy[0] = ($urandom_range(0, 2) == 0);
            rdy[1] = ($urandom_range(0, 2) == 0);
            drive_cycle(req_we, req_addr, req_data, rdy);
            total++; if (stall_seen !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall_seen, exp_stall); end
            total++; if (hit_seen !== exp_hit) begin bad++; $display("FAIL rnd_hit cyc=%0d got=%b exp=%b", cyc, hit_seen, exp_hit); end
            total++; if (valid_seen !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid_seen, exp_valid); end
            total++; if (full_seen !== exp_full) begin bad++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, full_seen, exp_full); end
            for (int i = 0; i < NUM_CH; i++) begin
                if (exp_valid[i]) begin
                    total++;
                    if (head_seen[i*DATA_W +: DATA_W] !== exp_head[i*DATA_W +: DATA_W]) begin
                        bad++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", cyc, i,
                                        head_seen[i*DATA_W +: DATA_W], exp_head[i*DATA_W +: DATA_W]);
                    end
                end
            end
            if (last_accept && req_ch >= 0) push_cnt[req_ch]++;
            hold = exp_stall;
            cyc++;
        end
        total++; if (cyc >= 2000) begin bad++; $display("FAIL rnd_budget pushes0=%0d pushes1=%0d need=%0d", push_cnt[0], push_cnt[1], 3 * DEPTH); end
        for (int c = 0; c < DEPTH + 2; c++) begin
            drive_cycle(1'b0, '0, '0, 3'b011);
            for (int i = 0; i < 2; i++) begin
                if (exp_valid[i]) begin
                    total++;
                    if (head_seen[i*DATA_W +: DATA_W] !== exp_head[i*DATA_W +: DATA_W]) begin
                        bad++; $display("FAIL rnd_drain ch=%0d got=%h exp=%h", i,
                                        head_seen[i*DATA_W +: DATA_W], exp_head[i*DATA_W +: DATA_W]);
                    end
                end
            end
        end
        total++; if (ch_valid !== 3'b000) begin bad++; $display("FAIL rnd_empty got=%b exp=000", ch_valid); end
        total++; if (ch_overflow !== exp_ovf) begin bad++; $display("FAIL rnd_overflow got=%b exp=%b", ch_overflow, exp_ovf); end
    endtask

    task automatic test_reset_mid();
        logic pre_stall;
        for (int v = 0; v < DEPTH; v++) drive_cycle(1'b1, BASE, DATA_W'($urandom), 3'b000);
        for (int v = 0; v < 5; v++) drive_cycle(1'b1, BASE + ADDR_W'(CH_LCD), DATA_W'($urandom), 3'b000);
        total++; if (ch_full !== 3'b001) begin bad++; $display("FAIL rmid_pre_full got=%b exp=001", ch_full); end
        cpu_we = 1'b1; cpu_addr = BASE; cpu_data = 16'h1234; ch_ready = '0;
        #1;
`ifdef MMIO_WQ_DROP_EN
        pre_stall = 1'b0;
`else
        pre_stall = 1'b1;
`endif
        total++; if (cpu_stall !== pre_stall) begin bad++; $display("FAIL rmid_pre_stall got=%b exp=%b", cpu_stall, pre_stall); end
        #1;
        reset = 1'b0;
        #1;
        total++; if (ch_valid !== 3'b000) begin bad++; $display("FAIL rmid_valid got=%b exp=000", ch_valid); end
        total++; if (ch_full !== 3'b000) begin bad++; $display("FAIL rmid_full got=%b exp=000", ch_full); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%b exp=0", cpu_stall); end
        @(posedge clk);
        @(negedge clk);
        cpu_we = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
        exp_ovf = '0;
        total++; if (ch_valid !== 3'b000) begin bad++; $display("FAIL rmid_after got=%b exp=000", ch_valid); end
    endtask

    initial begin
        exp_ovf = '0;
        test_reset();
        test_single_write();
        test_out_of_window();
`ifndef MMIO_WQ_DROP_EN
        test_stall_build();
        test_full_pop_push();
`else
        test_drop();
`endif
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_write_queue.md
Name: mmio_write_queue

Overview:
Parametrised memory-mapped write router between the CPU data port and slow write-only peripherals (pixel RAM/draw unit, LCD register, future devices). It decodes a window of NUM_CH consecutive word addresses and queues each accepted write in a per-channel FIFO. Each consumer drains its FIFO with a valid/ready handshake. It replaces the single hard-wired pixel-RAM "full" path with N independent buffered channels and a CPU stall.

Parameters:
NUM_CH, 3, number of output channels (1..8)
DEPTH, 8, entries per channel FIFO; power of two, >= 2
DATA_W, 16, write data width
ADDR_W, 14, CPU data address width
BASE_ADDR, 14'h3F00, address of channel 0; channel i at BASE_ADDR+i

Ports:
clk  in  1  system clock (CLK_25MHZ domain)
reset  in  1  asynchronous, active-low reset
cpu_we  in  1  CPU data write strobe
cpu_addr  in  ADDR_W  CPU data address
cpu_data  in  DATA_W  CPU write data
cpu_hit  out  1  cpu_addr inside window (combinational)
cpu_stall  out  1  write to a full channel; CPU must hold we/addr/data
ch_data  out  NUM_CH*DATA_W  head entry per channel; channel i at bits [i*DATA_W +: DATA_W]
ch_valid  out  NUM_CH  channel FIFO non-empty
ch_ready  in  NUM_CH  consumer pops the head this cycle when valid
ch_full  out  NUM_CH  channel FIFO holds DEPTH entries
ch_overflow  out  NUM_CH  sticky drop flag (MMIO_WQ_DROP_EN only; otherwise tied 0)

Behaviour:
- Reset (reset=0, async): all pointers 0, ch_valid=0, ch_full=0, ch_overflow=0, cpu_stall=0. ch_data after reset is don't-care; the bench checks it only while valid.
- Decode: the selected channel is sel = cpu_addr - BASE_ADDR.
  - cpu_hit = (cpu_addr >= BASE_ADDR) && (sel < NUM_CH).
  - An address outside the window is ignored: no push, no stall.
- Push: when cpu_we && cpu_hit && !ch_full[sel], cpu_data is written at the channel write pointer on the clk edge.
- Stall: cpu_stall = cpu_we && cpu_hit && ch_full[sel]. It is combinational from registered state only; the write is not taken.
  - The CPU holds the request; it is accepted in the first cycle ch_full[sel] is low.
- Pop: when ch_valid[i] && ch_ready[i], the read pointer advances on the clk edge. ch_ready while empty has no effect.
- FIFO view: show-ahead. ch_data[i] = storage[rd_ptr] combinationally.
- Latency: a write pushed at edge N gives ch_valid=1 with that data after edge N; a consumer can pop it at edge N+1.
- Pointers: log2(DEPTH)+1 bits with wrap-around.
  - empty when the pointers are equal.
  - full when the LSBs are equal and the MSBs differ.
- Simultaneous push and pop on the same channel:
  - Not full: both happen and the occupancy is unchanged.
  - Full: the pop happens and the push stalls this cycle. There is no full bypass; this keeps the stall path free of consumer inputs.
- Ordering: FIFO order within a channel. Channels are independent, with no ordering between them.
- Reset mid-operation: queued contents are discarded and the CPU request is dropped.

Optional Feature:
Macro MMIO_WQ_DROP_EN.
- Defined:
  - cpu_stall is tied 0.
  - A write to a full channel is discarded and sets ch_overflow[sel].
  - ch_overflow[sel] stays set until reset.
- Undefined: stall behaviour as above and ch_overflow tied 0.

Decomposition:
- Package mmio_wq_pkg holds the default constants: MMIO_WQ_BASE_ADDR and the channel indices CH_PRAM=0, CH_LCD=1, CH_SPARE=2.
- Package function clog2 gives the pointer width.
- One sub-module, mmio_wq_fifo (DEPTH, DATA_W): push/pop/full/valid/head. It is instantiated NUM_CH times in a generate loop.
- Decode, stall and the overflow flags stay in the top module.

Test Plan:
1. Reset, then write 16'hA5A5 to 14'h3F01 with ch_ready=0 -> ch_valid=3'b010 the next cycle; ch_data[31:16]=16'hA5A5; cpu_stall=0.
2. Write to 14'h3EFF and to 14'h3F03 -> cpu_hit=0, no ch_valid change, cpu_stall=0.
3. Eight writes 1..8 to channel 0 with ch_ready[0]=0, then a ninth write of 9:
   - Stall build: ch_full[0]=1 after the 8th write; cpu_stall=1 on the 9th.
   - Drain: raise ch_ready[0] for one cycle; the 9th is accepted the cycle after.
   - Data check: popped data sequence is 1..9.
4. Channel 2 full with ch_ready[2]=1 while writing 16'h0042 -> pop occurs; the push stalls exactly one cycle, then is accepted; the count returns to 8.
5. Interleaved writes to channels 0 and 1 with random ready -> per-channel order is preserved. Pointer wrap is exercised with at least 3*DEPTH pushes per channel.
6. Assert reset low mid-burst with channel 1 holding 5 entries -> ch_valid=0 and ch_full=0 immediately (async).
   - With MMIO_WQ_DROP_EN defined: a 9th write to full channel 0 -> cpu_stall=0, ch_overflow[0]=1, data dropped, and the flag persists until reset.
